// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo: AXI-Stream packet FIFO with FWFT output, level / packet
// counters, almost-full/empty flags, optional store-and-forward mode with
// oversize-packet release, and a synchronous flush.
module axis_pkt_fifo #(
  parameter  int WIDTH         = 8,
  parameter  int DEPTH         = 16,
  parameter  int AFULL_THRESH  = DEPTH - 2,
  parameter  int AEMPTY_THRESH = 1,
  parameter  int PACKET_MODE   = 0,
  localparam int ADDR_W        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [WIDTH-1:0]  s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [WIDTH-1:0]  m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [ADDR_W:0]   level,
  output logic [ADDR_W:0]   pkt_count,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              oversize
);

  typedef logic [WIDTH:0] entry_t;  // {tlast, tdata}

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   AF_L    = (ADDR_W + 1)'(AFULL_THRESH);
  localparam logic [ADDR_W:0]   AE_L    = (ADDR_W + 1)'(AEMPTY_THRESH);
  localparam logic [ADDR_W:0]   ONE_L   = 1;
  localparam logic [ADDR_W-1:0] ONE_P   = 1;

  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d, pkt_q, pkt_d;
  logic              rel_q, rel_d, ovs_q, ovs_d;

  entry_t head;
  logic   full, rel_set, rel_now, wr, rd, head_last, wr_last;

  // Handshakes and status outputs, all from registered state plus flush.
  always_comb begin
    head    = mem_q[rd_ptr_q];
    full    = (level_q == DEPTH_L);
    // A full FIFO with no complete packet can never finish a packet by
    // itself, so the head packet is released (and flagged) to avoid deadlock.
    rel_set = (PACKET_MODE != 0) && full && (pkt_q == '0);
    rel_now = rel_q || rel_set;
    s_axis_tready = !full && !flush;
    if (PACKET_MODE != 0)
      m_axis_tvalid = (level_q != '0) && ((pkt_q != '0) || rel_now) && !flush;
    else
      m_axis_tvalid = (level_q != '0) && !flush;
    m_axis_tdata  = head[WIDTH-1:0];
    m_axis_tlast  = head[WIDTH];
    head_last     = head[WIDTH];
    wr            = s_axis_tvalid && s_axis_tready;
    rd            = m_axis_tvalid && m_axis_tready;
    wr_last       = wr && s_axis_tlast;
    level         = level_q;
    pkt_count     = pkt_q;
    almost_full   = (level_q >= AF_L);
    almost_empty  = (level_q <= AE_L);
    oversize      = ovs_q || rel_set;
  end

  // Next-state: flush wins over any handshake in the same cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    pkt_d    = pkt_q;
    rel_d    = rel_q;
    ovs_d    = ovs_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      pkt_d    = '0;
      rel_d    = 1'b0;
      ovs_d    = 1'b0;
    end else begin
      if (wr) begin
        mem_d[wr_ptr_q] = {s_axis_tlast, s_axis_tdata};
        wr_ptr_d        = wr_ptr_q + ONE_P;
      end
      if (rd) rd_ptr_d = rd_ptr_q + ONE_P;
      if (wr && !rd) level_d = level_q + ONE_L;
      else if (!wr && rd) level_d = level_q - ONE_L;
      if (wr_last && !(rd && head_last)) pkt_d = pkt_q + ONE_L;
      else if (!wr_last && rd && head_last) pkt_d = pkt_q - ONE_L;
      // Release holds until the beat that ends the released packet leaves.
      rel_d = rel_now && !(rd && head_last);
      ovs_d = ovs_q || rel_set;
    end
  end

  // State registers; reset also zeroes the storage so the FWFT head reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      pkt_q    <= '0;
      rel_q    <= 1'b0;
      ovs_q    <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      pkt_q    <= pkt_d;
      rel_q    <= rel_d;
      ovs_q    <= ovs_d;
    end
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: instance 0 is cut-through, instance 1 is
// store-and-forward. A queue-based model predicts every output each cycle.
module tb_axis_pkt_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       fl [2];
  logic       sv [2];
  logic       sl [2];
  logic       mr [2];
  logic [7:0] sd [2];
  logic       st [2];
  logic       mv [2];
  logic       ml [2];
  logic       af [2];
  logic       ae [2];
  logic       ov [2];
  logic [7:0] md [2];
  logic [4:0] lv [2];
  logic [4:0] pc [2];

  always #5 clk = ~clk;

  axis_pkt_fifo #(.WIDTH(8), .DEPTH(DEPTH), .PACKET_MODE(0)) u_ct (
    .clk(clk), .rst(rst), .flush(fl[0]),
    .s_axis_tdata(sd[0]), .s_axis_tvalid(sv[0]), .s_axis_tlast(sl[0]), .s_axis_tready(st[0]),
    .m_axis_tdata(md[0]), .m_axis_tvalid(mv[0]), .m_axis_tlast(ml[0]), .m_axis_tready(mr[0]),
    .level(lv[0]), .pkt_count(pc[0]), .almost_full(af[0]), .almost_empty(ae[0]), .oversize(ov[0]));

  axis_pkt_fifo #(.WIDTH(8), .DEPTH(DEPTH), .PACKET_MODE(1)) u_pm (
    .clk(clk), .rst(rst), .flush(fl[1]),
    .s_axis_tdata(sd[1]), .s_axis_tvalid(sv[1]), .s_axis_tlast(sl[1]), .s_axis_tready(st[1]),
    .m_axis_tdata(md[1]), .m_axis_tvalid(mv[1]), .m_axis_tlast(ml[1]), .m_axis_tready(mr[1]),
    .level(lv[1]), .pkt_count(pc[1]), .almost_full(af[1]), .almost_empty(ae[1]), .oversize(ov[1]));

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: contents as a queue of {tlast, data}, plus the two flags.
  logic [8:0] mq [2][$];
  bit         mrel [2];
  bit         movs [2];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
  endtask

  task automatic rst_chk(input int d);
    chk($sformatf("d%0d rst tready", d), 32'(st[d]), 1);
    chk($sformatf("d%0d rst tvalid", d), 32'(mv[d]), 0);
    chk($sformatf("d%0d rst tdata", d), 32'(md[d]), 0);
    chk($sformatf("d%0d rst tlast", d), 32'(ml[d]), 0);
    chk($sformatf("d%0d rst level", d), 32'(lv[d]), 0);
    chk($sformatf("d%0d rst pkt", d), 32'(pc[d]), 0);
    chk($sformatf("d%0d rst afull", d), 32'(af[d]), 0);
    chk($sformatf("d%0d rst aempty", d), 32'(ae[d]), 1);
    chk($sformatf("d%0d rst ovs", d), 32'(ov[d]), 0);
  endtask

  // One clock cycle on instance d: drive, check against the model, advance model.
  task automatic cycle(input int d, input bit f, input bit v, input logic [7:0] data,
                       input bit last, input bit r);
    int size, cnt;
    bit pm, stuck, relnow, etr, etv, eov, wr, rd;
    fl[d] = f; sv[d] = v; sd[d] = data; sl[d] = last; mr[d] = r;
    #1;
    pm   = (d == 1);
    size = mq[d].size();
    cnt  = 0;
    for (int i = 0; i < size; i++) if (mq[d][i][8]) cnt++;
    stuck  = pm && (size == DEPTH) && (cnt == 0);
    relnow = mrel[d] || stuck;
    etr    = (size != DEPTH) && !f;
    etv    = (size != 0) && !f && (!pm || cnt != 0 || relnow);
    eov    = movs[d] || stuck;
    chk($sformatf("d%0d tready", d), 32'(st[d]), 32'(etr));
    chk($sformatf("d%0d tvalid", d), 32'(mv[d]), 32'(etv));
    chk($sformatf("d%0d level", d), 32'(lv[d]), 32'(size));
    chk($sformatf("d%0d pkt", d), 32'(pc[d]), 32'(cnt));
    chk($sformatf("d%0d afull", d), 32'(af[d]), 32'(size >= DEPTH - 2));
    chk($sformatf("d%0d aempty", d), 32'(ae[d]), 32'(size <= 1));
    chk($sformatf("d%0d ovs", d), 32'(ov[d]), 32'(eov));
    if (etv) begin
      chk($sformatf("d%0d tdata", d), 32'(md[d]), 32'(mq[d][0][7:0]));
      chk($sformatf("d%0d tlast", d), 32'(ml[d]), 32'(mq[d][0][8]));
    end
    wr = v && etr;
    rd = etv && r;
    @(posedge clk);
    if (f) begin
      mq[d].delete();
      mrel[d] = 1'b0;
      movs[d] = 1'b0;
    end else begin
      movs[d] = eov;
      mrel[d] = relnow;
      if (rd) begin
        if (mq[d][0][8]) mrel[d] = 1'b0;
        void'(mq[d].pop_front());
      end
      if (wr) mq[d].push_back({last, data});
    end
    @(negedge clk);
    fl[d] = 1'b0; sv[d] = 1'b0; sl[d] = 1'b0; mr[d] = 1'b0; sd[d] = 8'h00;
  endtask

  typedef struct {
    bit f, v; logic [7:0] data; bit last, r;
    bit e_trdy, e_tv; logic [7:0] e_data; bit e_last; int e_lvl, e_pc;
  } vec_t;

  initial begin
    vec_t tbl [8];
    int   rp;
    tbl[0] = '{0, 1, 8'h11, 0, 0,  1, 0, 8'h00, 0, 0, 0};
    tbl[1] = '{0, 1, 8'h22, 1, 0,  1, 1, 8'h11, 0, 1, 0};
    tbl[2] = '{0, 0, 8'h00, 0, 1,  1, 1, 8'h11, 0, 2, 1};
    tbl[3] = '{0, 0, 8'h00, 0, 1,  1, 1, 8'h22, 1, 1, 1};
    tbl[4] = '{0, 1, 8'h33, 0, 1,  1, 0, 8'h00, 0, 0, 0};
    tbl[5] = '{0, 0, 8'h00, 0, 0,  1, 1, 8'h33, 0, 1, 0};
    tbl[6] = '{1, 1, 8'h44, 0, 1,  0, 0, 8'h00, 0, 1, 0};
    tbl[7] = '{0, 0, 8'h00, 0, 0,  1, 0, 8'h00, 0, 0, 0};

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      fl[d] = 0; sv[d] = 0; sl[d] = 0; mr[d] = 0; sd[d] = 0;
      mrel[d] = 0; movs[d] = 0;
    end
    repeat (2) @(negedge clk);
    rst_chk(0);
    rst_chk(1);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors on the cut-through instance.
    for (int i = 0; i < 8; i++) begin
      fl[0] = tbl[i].f; sv[0] = tbl[i].v; sd[0] = tbl[i].data; sl[0] = tbl[i].last; mr[0] = tbl[i].r;
      #1;
      chk($sformatf("vec%0d tready", i), 32'(st[0]), 32'(tbl[i].e_trdy));
      chk($sformatf("vec%0d tvalid", i), 32'(mv[0]), 32'(tbl[i].e_tv));
      chk($sformatf("vec%0d level", i), 32'(lv[0]), 32'(tbl[i].e_lvl));
      chk($sformatf("vec%0d pkt", i), 32'(pc[0]), 32'(tbl[i].e_pc));
      if (tbl[i].e_tv) begin
        chk($sformatf("vec%0d tdata", i), 32'(md[0]), 32'(tbl[i].e_data));
        chk($sformatf("vec%0d tlast", i), 32'(ml[0]), 32'(tbl[i].e_last));
      end
      cycle(0, tbl[i].f, tbl[i].v, tbl[i].data, tbl[i].last, tbl[i].r);
    end

    // Fill to full, then drain in order.
    for (int i = 1; i <= 16; i++) cycle(0, 0, 1, 8'(i), 0, 0);
    chk("fill level", 32'(lv[0]), 16);
    chk("fill tready", 32'(st[0]), 0);
    chk("fill afull", 32'(af[0]), 1);
    cycle(0, 0, 1, 8'hFF, 0, 0);  // dropped: FIFO full
    for (int i = 0; i < 16; i++) cycle(0, 0, 0, 8'h00, 0, 1);
    chk("drain level", 32'(lv[0]), 0);
    chk("drain aempty", 32'(ae[0]), 1);

    // Concurrent read and write at level 5.
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 8'(8'h50 + i), 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 1, 8'(8'h60 + i), (i % 4) == 3, 1);
    chk("steady level", 32'(lv[0]), 5);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 8'h00, 0, 1);

    // Flush at level 7 with two packets, write in flush cycle dropped.
    for (int i = 0; i < 7; i++) cycle(0, 0, 1, 8'(8'h70 + i), (i == 2) || (i == 6), 0);
    chk("preflush level", 32'(lv[0]), 7);
    chk("preflush pkt", 32'(pc[0]), 2);
    cycle(0, 1, 1, 8'hEE, 1, 1);
    chk("flush level", 32'(lv[0]), 0);
    chk("flush pkt", 32'(pc[0]), 0);
    chk("flush ovs", 32'(ov[0]), 0);
    cycle(0, 0, 0, 8'h00, 0, 0);

    // Store-and-forward: nothing presented until tlast is written.
    cycle(1, 0, 1, 8'hA0, 0, 1);
    cycle(1, 0, 1, 8'hA1, 0, 1);
    chk("pm hold tvalid", 32'(mv[1]), 0);
    cycle(1, 0, 1, 8'hA2, 1, 1);
    chk("pm tvalid", 32'(mv[1]), 1);
    chk("pm head", 32'(md[1]), 32'h A0);
    chk("pm pkt1", 32'(pc[1]), 1);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 8'h00, 0, 1);
    chk("pm pkt0", 32'(pc[1]), 0);

    // Oversize packet: full with no tlast releases the head packet.
    for (int i = 0; i < 16; i++) cycle(1, 0, 1, 8'(8'h80 + i), 0, 1);
    chk("ovs flag", 32'(ov[1]), 1);
    chk("ovs tvalid", 32'(mv[1]), 1);
    for (int i = 0; i < 16; i++) cycle(1, 0, 0, 8'h00, 0, 1);
    cycle(1, 0, 1, 8'hC0, 1, 0);
    cycle(1, 0, 0, 8'h00, 0, 1);
    cycle(1, 0, 1, 8'hC1, 0, 1);
    chk("release cleared", 32'(mv[1]), 0);
    chk("ovs sticky", 32'(ov[1]), 1);
    cycle(1, 1, 0, 8'h00, 0, 0);
    chk("ovs flushed", 32'(ov[1]), 0);

    // Asynchronous reset between edges mid-packet.
    for (int i = 0; i < 9; i++) cycle(1, 0, 1, 8'(8'h90 + i), 0, 0);
    chk("prereset level", 32'(lv[1]), 9);
    #2 rst = 1'b1;
    #1 rst_chk(1);
    for (int d = 0; d < 2; d++) begin
      mq[d].delete(); mrel[d] = 0; movs[d] = 0;
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Random traffic with shifting read pressure.
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 900; c++) begin
        if (c % 100 == 0) rp = (c / 100) % 3 == 0 ? 20 : ((c / 100) % 3 == 1 ? 85 : 50);
        cycle(d, $urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
              $urandom_range(0, (d == 1) ? 9 : 4) == 0, $urandom_range(0, 99) < rp);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
